// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage that issues aligned loads and stores, waits for ack with a timeout,
// and produces a one-cycle writeback pulse with a fault flag.
module memory_stage #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        x_valid,
    output logic        x_ready,
    input  logic [31:0] pc_x,
    input  logic [31:0] inst_x,
    input  logic [31:0] alu_out,
    input  logic [31:0] write_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        m_valid,
    output logic [31:0] pc_m,
    output logic [31:0] inst_m,
    output logic [31:0] wb_data,
    output logic        fault
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [1:0] off;
    logic is_ld, is_st, is_mem, byte_x, half_x, mis, fire, timeout, byte_m, half_m;
    logic [2:0] f3x, f3m;
    logic [3:0] be_x;
    logic [31:0] wd_x, ld_data;
    logic [15:0] sh;
    always_comb begin
        x_ready  = state == IDLE;
        f3x      = inst_x[14:12];
        is_ld    = inst_x[6:0] == 7'b0000011;
        is_st    = inst_x[6:0] == 7'b0100011;
        is_mem   = is_ld || is_st;
        // unknown funct3 values fall through to word access
        byte_x   = f3x == 3'b000 || (is_ld && f3x == 3'b100);
        half_x   = f3x == 3'b001 || (is_ld && f3x == 3'b101);
        mis      = half_x ? alu_out[0] : byte_x ? 1'b0 : |alu_out[1:0];
        be_x     = byte_x ? 4'b0001 << alu_out[1:0] : half_x ? 4'b0011 << alu_out[1:0] : 4'b1111;
        wd_x     = byte_x ? {4{write_data[7:0]}} : half_x ? {2{write_data[15:0]}} : write_data;
        fire     = x_valid && x_ready;
        timeout  = !dmem_ack && cnt == CW'(ACK_TIMEOUT - 1);
        f3m      = inst_m[14:12];
        byte_m   = f3m == 3'b000 || f3m == 3'b100;
        half_m   = f3m == 3'b001 || f3m == 3'b101;
        sh       = 16'(dmem_rdata >> {off, 3'b000});
        ld_data  = byte_m ? {{24{~f3m[2] & sh[7]}}, sh[7:0]} :
                   half_m ? {{16{~f3m[2] & sh[15]}}, sh} : dmem_rdata;
        state_nx = state == IDLE ? (fire && is_mem && !mis ? BUSY : IDLE) :
                   state == BUSY ? (dmem_ack || timeout ? DONE : BUSY) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            off        <= '0;
            m_valid    <= 1'b0;
            fault      <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            pc_m       <= '0;
            inst_m     <= '0;
            wb_data    <= '0;
        end else begin
            m_valid <= 1'b0;
            if (fire) begin
                pc_m   <= pc_x;
                inst_m <= inst_x;
                if (!is_mem) begin
                    m_valid <= 1'b1;
                    fault   <= 1'b0;
                    wb_data <= alu_out;
                end else if (mis) begin
                    m_valid <= 1'b1;
                    fault   <= 1'b1;
                    wb_data <= '0;
                end else begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= is_st;
                    dmem_addr  <= {alu_out[31:2], 2'b00};
                    dmem_be    <= be_x;
                    dmem_wdata <= wd_x;
                    off        <= alu_out[1:0];
                    cnt        <= '0;
                end
            end
            if (state == BUSY) begin
                if (dmem_ack || timeout) begin
                    dmem_req <= 1'b0;
                    m_valid  <= 1'b1;
                    fault    <= !dmem_ack;
                    wb_data  <= dmem_ack && !dmem_we ? ld_data : '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed self-checking bench for memory_stage.
module tb_memory_stage;
    logic        clk = 0, rst_n = 0, x_valid = 0, x_ready;
    logic [31:0] pc_x = 0, inst_x = 0, alu_out = 0, write_data = 0;
    logic        dmem_req, dmem_we, dmem_ack = 0, m_valid, fault;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0, pc_m, inst_m, wb_data;
    logic [3:0]  dmem_be;
    int checks = 0, errors = 0, low, reqs;

    localparam logic [31:0] ADDI = 32'h02A00093, LB = 32'h00000083, LH = 32'h00001083,
                            LW = 32'h00002083, LBU = 32'h00004083, LHU = 32'h00005083,
                            SB = 32'h00000023, SH = 32'h00001023, SW = 32'h00002023;

    memory_stage #(.ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(x_ready),
        .pc_x(pc_x), .inst_x(inst_x), .alu_out(alu_out), .write_data(write_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .m_valid(m_valid), .pc_m(pc_m), .inst_m(inst_m), .wb_data(wb_data), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] alu,
                        input logic [31:0] wd);
        x_valid = 1; pc_x = pc; inst_x = inst; alu_out = alu; write_data = wd;
        step();
        x_valid = 0;
    endtask

    task automatic load_now(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        send(32'h80, inst, addr, 0);
        dmem_ack = 1; dmem_rdata = rdata;
        step();
        dmem_ack = 0;
        chk({tag, "_mvalid"}, m_valid, 1);
        chk({tag, "_wb"}, wb_data, exp);
        step();
    endtask

    initial begin
        step(); step();
        chk("rst_mvalid", m_valid, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_fault", fault, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wb", wb_data, 0);
        chk("rst_pcm", pc_m, 0);
        chk("rst_ready", x_ready, 1);
        rst_n = 1;
        step();

        send(32'h1000, ADDI, 32'h2A, 0);
        chk("addi_mvalid", m_valid, 1);
        chk("addi_wb", wb_data, 32'h2A);
        chk("addi_fault", fault, 0);
        chk("addi_req", dmem_req, 0);
        chk("addi_pcm", pc_m, 32'h1000);
        chk("addi_instm", inst_m, ADDI);
        step();
        chk("addi_pulse", m_valid, 0);

        low = 0;
        send(32'h1004, LB, 32'h103, 0);
        low += int'(!x_ready);
        chk("lb_req", dmem_req, 1);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_be", dmem_be, 4'b1000);
        chk("lb_we", dmem_we, 0);
        repeat (3) begin
            step();
            low += int'(!x_ready);
            chk("lb_hold_req", dmem_req, 1);
            chk("lb_hold_addr", dmem_addr, 32'h100);
        end
        dmem_ack = 1; dmem_rdata = 32'h80FF1234;
        step();
        dmem_ack = 0;
        low += int'(!x_ready);
        chk("lb_mvalid", m_valid, 1);
        chk("lb_wb", wb_data, 32'hFFFFFF80);
        chk("lb_fault", fault, 0);
        chk("lb_done_req", dmem_req, 0);
        step();
        low += int'(!x_ready);
        chk("lb_ready_low", low, 5);
        chk("lb_pulse", m_valid, 0);

        send(32'h1008, SH, 32'h202, 32'h0000BEEF);
        chk("sh_we", dmem_we, 1);
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
        chk("sh_addr", dmem_addr, 32'h200);
        dmem_ack = 1;
        step();
        dmem_ack = 0;
        chk("sh_mvalid", m_valid, 1);
        chk("sh_wb", wb_data, 0);
        step();
        chk("sh_once", m_valid, 0);

        send(32'h100C, SB, 32'h301, 32'h12345678);
        chk("sb_be", dmem_be, 4'b0010);
        chk("sb_wdata", dmem_wdata, 32'h78787878);
        dmem_ack = 1;
        step();
        dmem_ack = 0;
        step();
        send(32'h1010, SW, 32'h304, 32'h12345678);
        chk("sw_be", dmem_be, 4'b1111);
        chk("sw_wdata", dmem_wdata, 32'h12345678);
        dmem_ack = 1;
        step();
        dmem_ack = 0;
        step();

        load_now("lbu", LBU, 32'h101, 32'h0000AB00, 32'h000000AB);
        load_now("lh", LH, 32'h102, 32'h80010000, 32'hFFFF8001);
        load_now("lw", LW, 32'h104, 32'hCAFEF00D, 32'hCAFEF00D);

        send(32'h1014, LW, 32'h101, 0);
        chk("mis_req", dmem_req, 0);
        chk("mis_mvalid", m_valid, 1);
        chk("mis_fault", fault, 1);
        chk("mis_wb", wb_data, 0);
        chk("mis_ready", x_ready, 1);
        step();
        chk("mis_pulse", m_valid, 0);

        reqs = 0;
        send(32'h1018, LHU, 32'h40, 0);
        for (int i = 0; i < 40 && !m_valid; i++) begin
            reqs += int'(dmem_req);
            step();
        end
        chk("to_req_cycles", reqs, 16);
        chk("to_mvalid", m_valid, 1);
        chk("to_fault", fault, 1);
        chk("to_wb", wb_data, 0);
        dmem_ack = 1;
        step();
        chk("late_ack_mvalid", m_valid, 0);
        chk("late_ack_ready", x_ready, 1);
        step();
        dmem_ack = 0;
        chk("late_ack_mvalid2", m_valid, 0);
        chk("late_ack_req", dmem_req, 0);

        send(32'h101C, LW, 32'h500, 0);
        step();
        chk("rb_busy_req", dmem_req, 1);
        rst_n = 0;
        step();
        chk("rb_req", dmem_req, 0);
        chk("rb_mvalid", m_valid, 0);
        chk("rb_ready", x_ready, 1);
        rst_n = 1;
        step();
        chk("rb_after_ready", x_ready, 1);
        chk("rb_after_mvalid", m_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
